// File: rtl/condlogic_it_if.sv
// Decoder/ALU-side bundle for the conditional-execution unit.
// The master is the pipeline front end; the slave is condlogic_it.
interface condlogic_it_if #(
    parameter int unsigned MAXIT = 4
);
    localparam int unsigned LW = $clog2(MAXIT + 1);

    logic             Valid;
    logic             Stall;
    logic             Flush;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             ITStart;
    logic [3:0]       ITCond;
    logic [LW-1:0]    ITLen;
    logic [MAXIT-1:0] ITPat;

    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic             InIT;
    logic [LW-1:0]    ITRemain;
    logic             ITErr;

    modport master (
        output Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
               ITStart, ITCond, ITLen, ITPat,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, ITRemain, ITErr
    );

    modport slave (
        input  Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
               ITStart, ITCond, ITLen, ITPat,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, ITRemain, ITErr
    );
endinterface

// File: rtl/condlogic_it.sv
// Condition evaluation with split NZCV flag groups and an IT-block sequencer
// that predicates up to MAXIT following instructions.
module condlogic_it #(
    parameter int unsigned MAXIT = 4
) (
    input logic           clk,
    input logic           reset,
    condlogic_it_if.slave bus
);
    localparam int unsigned LW = $clog2(MAXIT + 1);

    typedef enum logic [0:0] {StIdle, StBlock} state_e;

    state_e           state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       itcond_q, itcond_d;
    logic [MAXIT-1:0] pat_q, pat_d;
    logic [LW-1:0]    remain_q, remain_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;

    logic       fire, in_it, pat_bit, cond_pass, cond_ex;
    logic       len_ok, it_ok, it_bad;
    logic       n, z, c, v;
    logic [3:0] eff_cond;

    assign fire  = bus.Valid & ~bus.Stall;
    assign in_it = (state_q == StBlock);
    assign {n, z, c, v} = flags_q;

    always_comb begin
        pat_bit = 1'b1;
        for (int i = 0; i < MAXIT; i++) begin
            if (idx_q == LW'(i)) pat_bit = pat_q[i];
        end
    end

    // Inside a block the slot's pattern bit selects firstcond or its inverse.
    assign eff_cond = in_it ? {itcond_q[3:1], itcond_q[0] ^ ~pat_bit} : bus.Cond;

    always_comb begin
        case (eff_cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign len_ok = (bus.ITLen != '0) && (bus.ITLen <= LW'(MAXIT));
    assign it_ok  = bus.ITStart & ~in_it & len_ok;
    assign it_bad = bus.ITStart & (in_it | ~len_ok);

    // An IT instruction outside a block always executes; any ITStart writes nothing.
    assign cond_ex = (bus.ITStart & ~in_it) | cond_pass;

    assign bus.CondEx   = cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex & bus.Valid & ~bus.ITStart;
    assign bus.MemWrite = bus.MemW & cond_ex & bus.Valid & ~bus.ITStart;
    assign bus.PCSrc    = bus.PCS & cond_ex & bus.Valid & ~bus.ITStart;
    assign bus.Flags    = flags_q;
    assign bus.InIT     = in_it;
    assign bus.ITRemain = remain_q;
    assign bus.ITErr    = err_q;

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        itcond_d = itcond_q;
        pat_d    = pat_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        err_d    = fire & it_bad;

        if (fire && cond_ex && !bus.ITStart) begin
            if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end

        if (bus.Flush) begin
            state_d  = StIdle;
            remain_d = '0;
            idx_d    = '0;
        end else if (fire) begin
            if (in_it) begin
                // A taken branch ends the block just like the last slot does.
                if (bus.PCSrc || (remain_q == LW'(1))) begin
                    state_d  = StIdle;
                    remain_d = '0;
                    idx_d    = '0;
                end else begin
                    remain_d = remain_q - LW'(1);
                    idx_d    = idx_q + LW'(1);
                end
            end else if (it_ok) begin
                state_d  = StBlock;
                itcond_d = bus.ITCond;
                pat_d    = bus.ITPat | MAXIT'(1);
                remain_d = bus.ITLen;
                idx_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            flags_q  <= '0;
            itcond_q <= '0;
            pat_q    <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            itcond_q <= itcond_d;
            pat_q    <= pat_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_condlogic_it.sv
// Vector-table bench for condlogic_it: each row drives one cycle, checks the
// combinational enables before the edge and the registered state after it.
module tb_condlogic_it;
    localparam int unsigned MAXIT = 4;
    localparam int NV = 30;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    condlogic_it_if #(.MAXIT(MAXIT)) bus ();

    condlogic_it #(.MAXIT(MAXIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vsf={Valid,Stall,Flush}, prm={PCS,RegW,MemW}, eo={CondEx,RegWrite,MemWrite,PCSrc}
    typedef struct {
        logic [2:0] vsf;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic [2:0] prm;
        logic       its;
        logic [3:0] itc;
        logic [2:0] itl;
        logic [3:0] itp;
        logic [3:0] eo;
        logic [3:0] flg;
        logic       init;
        logic [2:0] rem;
        logic       err;
    } vec_t;

    vec_t t[NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int i);
        vec_t r;
        r = t[i];
        @(negedge clk);
        {bus.Valid, bus.Stall, bus.Flush} = r.vsf;
        bus.Cond = r.cond;
        bus.ALUFlags = r.alu;
        bus.FlagW = r.fw;
        {bus.PCS, bus.RegW, bus.MemW} = r.prm;
        bus.ITStart = r.its;
        bus.ITCond = r.itc;
        bus.ITLen = r.itl;
        bus.ITPat = r.itp;
        #1;
        chk($sformatf("row%0d CondEx", i), 8'(bus.CondEx), 8'(r.eo[3]));
        chk($sformatf("row%0d RegWrite", i), 8'(bus.RegWrite), 8'(r.eo[2]));
        chk($sformatf("row%0d MemWrite", i), 8'(bus.MemWrite), 8'(r.eo[1]));
        chk($sformatf("row%0d PCSrc", i), 8'(bus.PCSrc), 8'(r.eo[0]));
        @(posedge clk);
        #1;
        chk($sformatf("row%0d Flags", i), 8'(bus.Flags), 8'(r.flg));
        chk($sformatf("row%0d InIT", i), 8'(bus.InIT), 8'(r.init));
        chk($sformatf("row%0d ITRemain", i), 8'(bus.ITRemain), 8'(r.rem));
        chk($sformatf("row%0d ITErr", i), 8'(bus.ITErr), 8'(r.err));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //          vsf    cond alu  fw    prm    its  itc  itl  itp  eo      flg  init rem  err
        t[0]  = '{3'b100,4'h0,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h0,1'b0,3'd0,1'b0};
        t[1]  = '{3'b100,4'hE,4'h4,2'b10,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'h4,1'b0,3'd0,1'b0};
        t[2]  = '{3'b100,4'h0,4'h0,2'b00,3'b011,1'b0,4'h0,3'd0,4'h0,4'b1110,4'h4,1'b0,3'd0,1'b0};
        t[3]  = '{3'b100,4'hE,4'hF,2'b01,3'b000,1'b0,4'h0,3'd0,4'h0,4'b1000,4'h7,1'b0,3'd0,1'b0};
        t[4]  = '{3'b100,4'h7,4'h0,2'b11,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h7,1'b0,3'd0,1'b0};
        // IT EQ, len 3, slot1 inverted; Z=1 gives 1,0,1 with a 2-cycle stall before slot1
        t[5]  = '{3'b100,4'h1,4'h0,2'b11,3'b010,1'b1,4'h0,3'd3,4'h5,4'b1000,4'h7,1'b1,3'd3,1'b0};
        t[6]  = '{3'b100,4'h1,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'h7,1'b1,3'd2,1'b0};
        t[7]  = '{3'b110,4'h0,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h7,1'b1,3'd2,1'b0};
        t[8]  = '{3'b110,4'h0,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h7,1'b1,3'd2,1'b0};
        t[9]  = '{3'b100,4'h0,4'h0,2'b11,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h7,1'b1,3'd1,1'b0};
        t[10] = '{3'b100,4'h1,4'h0,2'b00,3'b001,1'b0,4'h0,3'd0,4'h0,4'b1010,4'h7,1'b0,3'd0,1'b0};
        // illegal lengths 0 and MAXIT+1
        t[11] = '{3'b100,4'hE,4'h0,2'b00,3'b010,1'b1,4'h0,3'd0,4'h0,4'b1000,4'h7,1'b0,3'd0,1'b1};
        t[12] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b0,4'h0,3'd0,4'h0,4'b1000,4'h7,1'b0,3'd0,1'b0};
        t[13] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b1,4'h0,3'd5,4'h0,4'b1000,4'h7,1'b0,3'd0,1'b1};
        // 4-slot AL block, taken branch in slot 0 ends it
        t[14] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b1,4'hE,3'd4,4'h0,4'b1000,4'h7,1'b1,3'd4,1'b0};
        t[15] = '{3'b100,4'h0,4'h0,2'b00,3'b100,1'b0,4'h0,3'd0,4'h0,4'b1001,4'h7,1'b0,3'd0,1'b0};
        // ITStart inside a block, then Flush on the next slot with a concurrent flag write
        t[16] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b1,4'h0,3'd2,4'h3,4'b1000,4'h7,1'b1,3'd2,1'b0};
        t[17] = '{3'b100,4'hE,4'h0,2'b00,3'b010,1'b1,4'h0,3'd1,4'h1,4'b1000,4'h7,1'b1,3'd1,1'b1};
        t[18] = '{3'b101,4'h1,4'h8,2'b10,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'hB,1'b0,3'd0,1'b0};
        t[19] = '{3'b100,4'h1,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'hB,1'b0,3'd0,1'b0};
        t[20] = '{3'b000,4'h1,4'hF,2'b11,3'b011,1'b0,4'h0,3'd0,4'h0,4'b1000,4'hB,1'b0,3'd0,1'b0};
        t[21] = '{3'b100,4'hA,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'hB,1'b0,3'd0,1'b0};
        t[22] = '{3'b100,4'hD,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'hB,1'b0,3'd0,1'b0};
        t[23] = '{3'b100,4'h8,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b1100,4'hB,1'b0,3'd0,1'b0};
        // ITStart on the last slot of a 1-slot block is illegal
        t[24] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b1,4'hE,3'd1,4'h0,4'b1000,4'hB,1'b1,3'd1,1'b0};
        t[25] = '{3'b100,4'h0,4'h0,2'b00,3'b010,1'b1,4'h0,3'd2,4'h0,4'b1000,4'hB,1'b0,3'd0,1'b1};
        // block that is cut short by asynchronous reset
        t[26] = '{3'b100,4'hE,4'h0,2'b00,3'b000,1'b1,4'h0,3'd4,4'hF,4'b1000,4'hB,1'b1,3'd4,1'b0};
        t[27] = '{3'b100,4'h0,4'h0,2'b00,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'hB,1'b1,3'd3,1'b0};
        // after reset: C,V-only write, then a failed condition leaves flags alone
        t[28] = '{3'b100,4'hE,4'hF,2'b01,3'b000,1'b0,4'h0,3'd0,4'h0,4'b1000,4'h3,1'b0,3'd0,1'b0};
        t[29] = '{3'b100,4'h0,4'hF,2'b11,3'b010,1'b0,4'h0,3'd0,4'h0,4'b0000,4'h3,1'b0,3'd0,1'b0};

        reset = 1'b0;
        {bus.Valid, bus.Stall, bus.Flush} = 3'b000;
        bus.Cond = 4'h0;
        bus.ALUFlags = 4'h0;
        bus.FlagW = 2'b00;
        {bus.PCS, bus.RegW, bus.MemW} = 3'b000;
        bus.ITStart = 1'b0;
        bus.ITCond = 4'h0;
        bus.ITLen = '0;
        bus.ITPat = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset Flags", 8'(bus.Flags), 8'h0);
        chk("reset InIT", 8'(bus.InIT), 8'h0);
        chk("reset ITRemain", 8'(bus.ITRemain), 8'h0);
        chk("reset ITErr", 8'(bus.ITErr), 8'h0);
        chk("reset CondEx EQ", 8'(bus.CondEx), 8'h0);
        reset = 1'b1;

        for (int i = 0; i < 28; i++) run_row(i);

        // Mid-block reset must clear everything before any further clock edge.
        @(negedge clk);
        bus.Valid = 1'b0;
        bus.ITStart = 1'b0;
        reset = 1'b0;
        #1;
        chk("async InIT", 8'(bus.InIT), 8'h0);
        chk("async ITRemain", 8'(bus.ITRemain), 8'h0);
        chk("async Flags", 8'(bus.Flags), 8'h0);
        chk("async ITErr", 8'(bus.ITErr), 8'h0);
        #1;
        reset = 1'b1;

        for (int i = 28; i < NV; i++) run_row(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/condlogic_it.md
# condlogic_it

Conditional-execution unit for the ARM datapath and the successor to the two-flag-group condition logic. It keeps the NZCV flags in two independently enabled groups and evaluates all 16 condition codes. It adds a parametrised IT-block sequencer that supplies predicates for up to MAXIT following instructions, a valid/stall qualifier, and a flush input. It sits between the decoder/ALU and the register-file, memory and PC-select enables.

## Interface
- MAXIT, 4: maximum IT-block length (1..8)
- LW, $clog2(MAXIT+1): width of IT length/remaining-count fields (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Valid  input  1  an instruction is present this cycle
- Stall  input  1  hold; no state change while high
- Flush  input  1  discard IT state (branch or exception redirect)
- Cond  input  4  instruction condition field
- ALUFlags  input  4  {N,Z,C,V} from the ALU
- FlagW  input  2  [1]=write N,Z; [0]=write C,V
- PCS, RegW, MemW  input  1 each  raw decoder enables
- ITStart  input  1  current instruction is an IT instruction
- ITCond  input  4  firstcond of the IT instruction
- ITLen  input  LW  number of predicated instructions (1..MAXIT)
- ITPat  input  MAXIT  bit i: 1 = slot i uses firstcond, 0 = inverse; bit 0 ignored, always 1
- PCSrc, RegWrite, MemWrite  output  1 each  gated enables
- CondEx  output  1  effective condition passed
- Flags  output  4  architectural {N,Z,C,V}
- InIT  output  1  IT block active
- ITRemain  output  LW  predicated slots still to execute
- ITErr  output  1  one-cycle pulse: illegal IT request

## Operation
- Fire = Valid & ~Stall. All state advances only on Fire, except Flush.
- Effective condition:
  - InIT=0: EffCond = Cond.
  - InIT=1: EffCond = {ITCondR[3:1], ITCondR[0] ^ ~PatR[idx]}, where idx = slot index.
  - Cond is ignored inside a block.
- Condition table (Flags registered): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 true.
- Gated outputs: RegWrite=RegW&CondEx&Valid; MemWrite=MemW&CondEx&Valid; PCSrc=PCS&CondEx&Valid. All are combinational.
- Flag groups: on Fire with CondEx=1, N,Z load when FlagW[1] is set, and C,V load when FlagW[0] is set.
- IT accept: on Fire with ITStart=1, InIT=0, and 1<=ITLen<=MAXIT:
  - capture ITCondR=ITCond, PatR=ITPat, ITRemain=ITLen, idx=0.
  - The IT instruction itself has CondEx=1 and writes nothing.
- IT illegal: ITStart with InIT=1, or ITLen=0, or ITLen>MAXIT.
  - The request is ignored; ITErr pulses the next cycle.
  - An existing block continues; the instruction is treated as a NOP slot consumer when inside a block.
- Block advance: on each Fire while InIT, ITRemain decrements and idx increments. InIT clears when ITRemain reaches 0.
- Early exit: a taken branch (PCSrc=1) inside a block terminates it (InIT=0, ITRemain=0) at that edge.
- ITCondR 1110: all slots are true regardless of PatR.

## Timing
- Reset values: Flags=0000, InIT=0, ITRemain=0, idx=0, ITErr=0. Combinational outputs follow from these.
- Reset asserted mid-block clears the block immediately and asynchronously.
- Flush takes precedence over Fire. At the edge with Flush=1, InIT=0 and ITRemain=0. Flags update normally from a concurrent Fire.
- Latency: flags written at edge k are visible to the condition evaluated in cycle k+1; there is no bypass.
- First predicated slot is the first Fire after the IT instruction's Fire. Stalled cycles consume no slot.
- Simultaneous ITStart and block termination in the same cycle (last slot): ITStart is illegal, since InIT=1 in that cycle.

## Test plan
- Reset, then Cond=0000 with Flags=0000 -> CondEx=0. Write ALUFlags=0100 with FlagW=10 -> Flags=0100, EQ passes next cycle, RegWrite=RegW.
- FlagW=01 with ALUFlags=1111 from Flags=0000 -> Flags=0011; N,Z are untouched. Repeat with CondEx=0 -> no change.
- IT: ITCond=0000 (EQ), ITLen=3, ITPat=x01 (slot1 inverse), Z=1 -> slot CondEx sequence 1,0,1. InIT drops after the third Fire. ITRemain sequence is 3,2,1,0.
- Same block with Stall high for 2 cycles between slots -> ITRemain holds, and the sequence is unchanged.
- Taken branch in slot 0 of a 4-slot block -> InIT=0 next cycle. Flush mid-block -> InIT=0, with the subsequent Cond honoured.
- ITLen=0, ITLen=MAXIT+1, and ITStart inside a block -> ITErr one-cycle pulse each, no state change. Async reset low mid-block -> all state cleared without a clock.
